// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the main-memory port arbiter: FSM states, grant owner and MemoryOp encodings.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // MemoryOp encodings; bit 2 selects zero-extension for sub-word loads
  typedef enum logic [2:0] {
    MEMOP_BYTE  = 3'b000,
    MEMOP_HALF  = 3'b001,
    MEMOP_WORD  = 3'b010,
    MEMOP_BYTEU = 3'b100,
    MEMOP_HALFU = 3'b101
  } memory_op_e;

  function automatic grant_t otherSide(input grant_t g);
    return (g == GRANT_I) ? GRANT_D : GRANT_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin picker: a lone request wins outright, on contention the side
// that did not win last time goes next.
module rr_grant2
  import mem_port_arbiter_pkg::*;
(
  input  logic   iReq,
  input  logic   dReq,
  input  grant_t lastGrant,
  output logic   grantValid,
  output grant_t grant
);

  // Combinational pick from the current requests and the previous owner
  always_comb begin
    grantValid = iReq | dReq;
    grant      = otherSide(lastGrant);
    if (iReq && !dReq) begin
      grant = GRANT_I;
    end else if (dReq && !iReq) begin
      grant = GRANT_D;
    end else begin
      grant = otherSide(lastGrant);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared main-memory port between fetch refills and memory-stage loads/stores.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort a transaction after TIMEOUT_CYCLES BUSY cycles.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [2:0]            d_op,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [2:0]            mem_op,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  err
);

  arb_state_t            state_r;
  grant_t                lastGrant_r;
  grant_t                grant_s;
  logic                  grantValid_s;
  logic                  busy_s;
  logic                  complete_s;
  logic                  timeout_s;
  logic [DATA_WIDTH-1:0] respData_s;

  logic                  memReq_r;
  logic                  memWe_r;
  logic [2:0]            memOp_r;
  logic [ADDR_WIDTH-1:0] memAddr_r;
  logic [DATA_WIDTH-1:0] memWdata_r;
  logic [DATA_WIDTH-1:0] iRdata_r;
  logic [DATA_WIDTH-1:0] dRdata_r;
  logic                  iDone_r;
  logic                  dDone_r;

  rr_grant2 uRrGrant (
    .iReq       (i_req),
    .dReq       (d_req),
    .lastGrant  (lastGrant_r),
    .grantValid (grantValid_s),
    .grant      (grant_s)
  );

  // lastGrant_r doubles as the owner of the transaction in flight
  assign busy_s     = (state_r == BUSY_I) || (state_r == BUSY_D);
  assign complete_s = busy_s && (mem_ready || timeout_s);
  assign respData_s = mem_ready ? mem_rdata : {DATA_WIDTH{1'b0}};

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] busyCnt_r;
  logic             err_r;

  assign timeout_s = (busyCnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: zero outside BUSY, so it is clear on the first cycle after a grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busyCnt_r <= {CNT_W{1'b0}};
    end else if (busy_s) begin
      busyCnt_r <= busyCnt_r + CNT_W'(1);
    end else begin
      busyCnt_r <= {CNT_W{1'b0}};
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (busy_s && timeout_s && !mem_ready) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign timeout_s = 1'b0;
  assign err       = 1'b0;
`endif

  // Arbitration FSM; every requester- and memory-facing output is a register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      lastGrant_r <= GRANT_D;
      memReq_r    <= 1'b0;
      memWe_r     <= 1'b0;
      memOp_r     <= 3'b000;
      memAddr_r   <= {ADDR_WIDTH{1'b0}};
      memWdata_r  <= {DATA_WIDTH{1'b0}};
      iRdata_r    <= {DATA_WIDTH{1'b0}};
      dRdata_r    <= {DATA_WIDTH{1'b0}};
      iDone_r     <= 1'b0;
      dDone_r     <= 1'b0;
    end else begin
      iDone_r <= 1'b0;
      dDone_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grantValid_s) begin
            lastGrant_r <= grant_s;
            memReq_r    <= 1'b1;
            if (grant_s == GRANT_I) begin
              state_r    <= BUSY_I;
              memWe_r    <= 1'b0;
              memOp_r    <= MEMOP_WORD;
              memAddr_r  <= i_addr;
              memWdata_r <= {DATA_WIDTH{1'b0}};
            end else begin
              state_r    <= BUSY_D;
              memWe_r    <= d_we;
              memOp_r    <= d_op;
              memAddr_r  <= d_addr;
              memWdata_r <= d_wdata;
            end
          end
        end
        BUSY_I: begin
          if (complete_s) begin
            memReq_r <= 1'b0;
            state_r  <= RESP_I;
            iDone_r  <= 1'b1;
            iRdata_r <= respData_s;
          end
        end
        BUSY_D: begin
          if (complete_s) begin
            memReq_r <= 1'b0;
            state_r  <= RESP_D;
            dDone_r  <= 1'b1;
            // Stores leave the last load data visible to the memory stage
            if (!memWe_r) begin
              dRdata_r <= respData_s;
            end
          end
        end
        RESP_I, RESP_D: begin
          state_r <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          memReq_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = memReq_r;
  assign mem_we    = memWe_r;
  assign mem_op    = memOp_r;
  assign mem_addr  = memAddr_r;
  assign mem_wdata = memWdata_r;
  assign i_rdata   = iRdata_r;
  assign d_rdata   = dRdata_r;
  assign i_done    = iDone_r;
  assign d_done    = dDone_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: expected memory requests and completions queued at stimulus time,
// checked when mem_req rises and when a done pulse appears. Define MEM_ARB_TIMEOUT_EN for the watchdog path.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk;
  logic          rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_done;
  logic          d_req;
  logic          d_we;
  logic [2:0]    d_op;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          mem_req;
  logic          mem_we;
  logic [2:0]    mem_op;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          err;

  mem_port_arbiter #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_op      (d_op),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_op    (mem_op),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // side: 0 = fetch, 1 = memory stage; ir/dr are the rdata outputs expected after completion
  typedef struct {
    bit            side;
    logic          we;
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] ir;
    logic [DW-1:0] dr;
  } exp_t;

  exp_t          expQ[$];
  int            checks = 0;
  int            errors = 0;
  int            doneCnt = 0;
  logic [DW-1:0] expIR = 32'h0;
  logic [DW-1:0] expDR = 32'h0;

  // memory model and monitor state
  bit            memEnable = 1'b0;
  int            memDelay = 0;
  bit            spurious = 1'b0;
  int            waitCnt = 0;
  logic [DW-1:0] memData = 32'h0;
  logic          prevMemReq = 1'b0;
  logic          prevIDone = 1'b0;
  logic          prevDDone = 1'b0;
  bit            checkGap = 1'b0;
  bit            seenFall = 1'b0;
  int            lowRun = 0;

  task automatic push(input bit side, input logic we, input logic [2:0] op,
                      input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input logic [DW-1:0] data);
    exp_t e;
    e.side = side; e.we = we; e.op = op; e.addr = addr; e.wdata = wdata;
    if (!side) expIR = data;
    else if (!we) expDR = data;
    e.ir = expIR;
    e.dr = expDR;
    expQ.push_back(e);
  endtask

  // One cycle: sample at the falling edge, score, then drive the memory model for the next rising edge
  task automatic step();
    exp_t e;
    @(negedge clk);
    checks++;
    if (i_done === 1'b1 && d_done === 1'b1) begin
      errors++; $display("FAIL both_done: i_done=%b d_done=%b, required at most one", i_done, d_done);
    end
    if (mem_req === 1'b1 && prevMemReq === 1'b0) begin
      if (checkGap && seenFall) begin
        checks++;
        if (lowRun !== 2) begin
          errors++; $display("FAIL req_gap: mem_req low for %0d cycles, required 2", lowRun);
        end
      end
      checks++;
      if (expQ.size() == 0) begin
        errors++; $display("FAIL unexpected_req: mem_req rose with nothing expected (addr=%h)", mem_addr);
      end else begin
        e = expQ[0];
        if (mem_we !== e.we || mem_op !== e.op || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
          errors++;
          $display("FAIL req_fields: we=%b op=%b addr=%h wdata=%h, required we=%b op=%b addr=%h wdata=%h",
                   mem_we, mem_op, mem_addr, mem_wdata, e.we, e.op, e.addr, e.wdata);
        end
      end
      lowRun = 0;
    end else if (mem_req !== 1'b1 && prevMemReq === 1'b1) begin
      seenFall = 1'b1;
      lowRun = 1;
    end else if (mem_req !== 1'b1) begin
      lowRun++;
    end
    if (i_done === 1'b1 || d_done === 1'b1) begin
      doneCnt++;
      checks++;
      if ((i_done === 1'b1 && prevIDone === 1'b1) || (d_done === 1'b1 && prevDDone === 1'b1)) begin
        errors++; $display("FAIL done_width: done high on consecutive cycles, required one-cycle pulse");
      end
      checks++;
      if (expQ.size() == 0) begin
        errors++; $display("FAIL unexpected_done: i_done=%b d_done=%b with nothing expected", i_done, d_done);
      end else begin
        e = expQ.pop_front();
        if (d_done !== e.side) begin
          errors++; $display("FAIL done_side: d_done=%b, required side %0d", d_done, e.side);
        end
        checks++;
        if (i_rdata !== e.ir || d_rdata !== e.dr) begin
          errors++; $display("FAIL rdata: i_rdata=%h d_rdata=%h, required %h %h", i_rdata, d_rdata, e.ir, e.dr);
        end
      end
    end
    prevMemReq = mem_req;
    prevIDone  = i_done;
    prevDDone  = d_done;
    if (mem_ready) begin
      mem_ready = 1'b0;
    end else if (spurious) begin
      mem_ready = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      spurious  = 1'b0;
    end else if (mem_req === 1'b1 && memEnable) begin
      waitCnt++;
      if (waitCnt > memDelay) begin
        mem_ready = 1'b1;
        mem_rdata = memData;
        memData   = memData + 32'd1;
        waitCnt   = 0;
      end
    end else begin
      waitCnt = 0;
    end
  endtask

  task automatic wait_done(input int budget, input string name, output int n);
    int start;
    start = doneCnt;
    n = 0;
    while (doneCnt == start && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (doneCnt == start) begin
      errors++; $display("FAIL %s: no done pulse within %0d cycles", name, budget);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    expQ.delete();
    expIR = 32'h0;
    expDR = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({mem_req, mem_we, i_done, d_done, err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: req/we/idone/ddone/err=%b, required 00000",
                         {mem_req, mem_we, i_done, d_done, err});
    end
    checks++;
    if (mem_op !== 3'b000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_mem: op=%b addr=%h wdata=%h, required zeros", mem_op, mem_addr, mem_wdata);
    end
    checks++;
    if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: i_rdata=%h d_rdata=%h, required 0", i_rdata, d_rdata);
    end
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: mem_req=%b, required 0", mem_req);
    end
  endtask

  task automatic test_fetch();
    int n;
    memEnable = 1'b1; memDelay = 2; memData = 32'hDEAD_BEEF;
    d_we = 1'b1; d_op = 3'b101; d_addr = 32'hFFFF_FFF0; d_wdata = 32'hFFFF_FFFF;
    i_addr = 32'h100; i_req = 1'b1;
    push(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF);
    wait_done(20, "fetch_done", n);
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL fetch_latency: done after %0d cycles, required 4", n);
    end
    checks++;
    if (i_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL fetch_rdata: i_rdata=%h, required deadbeef", i_rdata);
    end
    i_req = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_min_latency();
    int n;
    memDelay = 0; memData = 32'h8000_0001;
    d_we = 1'b0; d_op = 3'b101; d_addr = 32'h3000; d_wdata = 32'hAAAA_5555; d_req = 1'b1;
    push(1'b1, 1'b0, 3'b101, 32'h3000, 32'h0, 32'h8000_0001);
    wait_done(20, "load_done", n);
    checks++;
    if (n !== 2) begin
      errors++; $display("FAIL min_latency: done after %0d cycles, required 2", n);
    end
    d_req = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_store();
    int n;
    memDelay = 1; memData = 32'h0BAD_F00D;
    d_we = 1'b1; d_op = 3'b000; d_addr = 32'h2004; d_wdata = 32'h1234_5678; d_req = 1'b1;
    push(1'b1, 1'b1, 3'b000, 32'h2004, 32'h1234_5678, 32'h0);
    wait_done(20, "store_done", n);
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL store_latency: done after %0d cycles, required 3", n);
    end
    checks++;
    if (d_rdata !== 32'h8000_0001) begin
      errors++; $display("FAIL store_rdata: d_rdata=%h, required 80000001 (unchanged)", d_rdata);
    end
    d_req = 1'b0; d_we = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_drop();
    int n;
    memDelay = 3; memData = 32'h1357_9BDF;
    i_addr = 32'h180; i_req = 1'b1;
    push(1'b0, 1'b0, 3'b010, 32'h180, 32'h0, 32'h1357_9BDF);
    step();
    i_req = 1'b0; i_addr = 32'hFFFF_FFFC;
    wait_done(20, "drop_done", n);
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL drop_latency: done after %0d more cycles, required 4", n);
    end
    repeat (2) step();
  endtask

  task automatic test_spurious();
    int n;
    spurious = 1'b1;
    step();
    step();
    checks++;
    if (i_done !== 1'b0 || d_done !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL spurious: idone=%b ddone=%b req=%b, required 000", i_done, d_done, mem_req);
    end
    step();
    memDelay = 0; memData = 32'h5555_AAAA;
    i_addr = 32'h240; i_req = 1'b1;
    push(1'b0, 1'b0, 3'b010, 32'h240, 32'h0, 32'h5555_AAAA);
    wait_done(20, "post_spurious_done", n);
    checks++;
    if (n !== 2) begin
      errors++; $display("FAIL post_spurious_latency: done after %0d cycles, required 2", n);
    end
    i_req = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset_mid();
    int n;
    memEnable = 1'b0; memData = 32'h2468_ACE0;
    d_we = 1'b0; d_op = 3'b010; d_addr = 32'h500; d_req = 1'b1;
    push(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h2468_ACE0);
    repeat (3) step();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL busy_d_req: mem_req=%b, required 1", mem_req);
    end
    rst_n = 1'b0;
    expQ.delete(); expIR = 32'h0; expDR = 32'h0;
    step();
    checks++;
    if (mem_req !== 1'b0 || d_done !== 1'b0 || i_done !== 1'b0 || mem_addr !== 32'h0 || d_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_mid: req=%b ddone=%b idone=%b addr=%h d_rdata=%h, required all 0",
                         mem_req, d_done, i_done, mem_addr, d_rdata);
    end
    rst_n = 1'b1; memEnable = 1'b1; memDelay = 0;
    push(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h2468_ACE0);
    wait_done(10, "regrant_done", n);
    checks++;
    if (n !== 2) begin
      errors++; $display("FAIL regrant_latency: done after %0d cycles, required 2", n);
    end
    d_req = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_round_robin();
    int start;
    int k;
    d_req = 1'b0; i_req = 1'b0;
    do_reset();
    memEnable = 1'b1; memDelay = 1; memData = 32'hA000_0000;
    i_addr = 32'h300; d_addr = 32'h400; d_we = 1'b0; d_op = 3'b100; d_wdata = 32'h0;
    push(1'b0, 1'b0, 3'b010, 32'h300, 32'h0, 32'hA000_0000);
    push(1'b1, 1'b0, 3'b100, 32'h400, 32'h0, 32'hA000_0001);
    push(1'b0, 1'b0, 3'b010, 32'h300, 32'h0, 32'hA000_0002);
    push(1'b1, 1'b0, 3'b100, 32'h400, 32'h0, 32'hA000_0003);
    seenFall = 1'b0; checkGap = 1'b1;
    i_req = 1'b1; d_req = 1'b1;
    start = doneCnt; k = 0;
    while (doneCnt - start < 4 && k < 80) begin
      step();
      k++;
    end
    checks++;
    if (doneCnt - start !== 4) begin
      errors++; $display("FAIL rr_count: %0d completions, required 4", doneCnt - start);
    end
    i_req = 1'b0; d_req = 1'b0; checkGap = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_timeout();
    int n;
    memEnable = 1'b0;
    i_addr = 32'h700; i_req = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
    push(1'b0, 1'b0, 3'b010, 32'h700, 32'h0, 32'h0);
    wait_done(40, "timeout_done", n);
    checks++;
    if (n !== 9) begin
      errors++; $display("FAIL timeout_latency: done after %0d cycles, required 9", n);
    end
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL timeout_err: err=%b, required 1", err);
    end
    i_req = 1'b0;
    repeat (3) step();
    checks++;
    if (err !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL err_sticky: err=%b mem_req=%b, required 1 0", err, mem_req);
    end
    do_reset();
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_reset: err=%b, required 0", err);
    end
    memEnable = 1'b1;
`else
    memData = 32'h600D_CAFE;
    push(1'b0, 1'b0, 3'b010, 32'h700, 32'h0, 32'h600D_CAFE);
    n = doneCnt;
    repeat (20) step();
    checks++;
    if (mem_req !== 1'b1 || err !== 1'b0 || doneCnt !== n) begin
      errors++; $display("FAIL no_timeout: mem_req=%b err=%b dones=%0d, required 1 0 0",
                         mem_req, err, doneCnt - n);
    end
    memEnable = 1'b1; memDelay = 0;
    wait_done(10, "late_ready_done", n);
    i_req = 1'b0;
    repeat (2) step();
`endif
  endtask

  initial begin
    rst_n = 1'b0; i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_op = 3'b000; d_addr = 32'h0; d_wdata = 32'h0;
    mem_rdata = 32'h0; mem_ready = 1'b0;
    test_reset();
    test_fetch();
    test_min_latency();
    test_store();
    test_drop();
    test_spurious();
    test_reset_mid();
    test_round_robin();
    test_timeout();
    checks++;
    if (expQ.size() != 0) begin
      errors++; $display("FAIL leftover: %0d expected transactions never completed, required 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
